// File: rtl/fir_stream_ctrl.sv
// fir_stream_ctrl: valid/ready sequencer that owns the 8-tap FIR delay line and
// tracks the FIR's one-cycle registered latency, with warm-up, flush and stall handling.
module fir_stream_ctrl #(
  parameter int NB_DATA     = 8,
  parameter int N_TAPS      = 8,
  parameter bit EMIT_WARMUP = 1'b0
) (
  input  logic                      i_clk_G,
  input  logic                      i_rst,
  input  logic                      i_enable,
  input  logic                      i_flush,
  input  logic [NB_DATA-1:0]        i_data,
  input  logic                      i_valid,
  output logic                      o_ready,
  output logic [N_TAPS*NB_DATA-1:0] o_taps,
  input  logic [NB_DATA-1:0]        i_fir_y,
  output logic [NB_DATA-1:0]        o_data,
  output logic                      o_valid,
  input  logic                      i_ready,
  output logic [1:0]                o_state,
  output logic                      o_busy
);

  localparam int CW = $clog2(N_TAPS + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(N_TAPS);
  localparam logic [CW-1:0] LAST_IDX = CW'(N_TAPS - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_RUN   = 2'd2,
    ST_FLUSH = 2'd3
  } state_t;

  state_t                           state;
  logic [N_TAPS-1:0][NB_DATA-1:0]   taps;
  logic [CW-1:0]                    fill_cnt;
  logic [CW-1:0]                    flush_cnt;
  logic                             inflight;
  logic                             emit_pending;

  logic active;
  logic out_free;
  logic accept;
  logic inject;
  logic shift;
  logic fill_done;
  logic shift_emits;
  logic abort_fill;
  logic leave_active;
  logic flush_done;
  logic go_idle;
  logic [NB_DATA-1:0] shift_in;

  // A shift may only happen once the previous result has left the FIR and
  // the output register is free (or being drained this very cycle).
  assign active   = (state == ST_FILL) || (state == ST_RUN);
  assign out_free = !inflight && (!o_valid || i_ready);
  assign o_ready  = active && i_enable && out_free;
  assign accept   = i_valid && o_ready;
  assign inject   = (state == ST_FLUSH) && out_free && (flush_cnt < LAST_IDX);
  assign shift    = accept || inject;
  assign shift_in = inject ? '0 : i_data;

  assign fill_done   = accept && (state == ST_FILL) && (fill_cnt == LAST_IDX);
  assign shift_emits = inject || (state == ST_RUN) || EMIT_WARMUP || fill_done;

  assign abort_fill   = (state == ST_FILL) && (fill_cnt == '0) && !accept;
  assign leave_active = active && !i_flush && !i_enable && !inflight && !o_valid;
  assign flush_done   = (state == ST_FLUSH) && (flush_cnt == LAST_IDX) &&
                        !inflight && o_valid && i_ready;
  assign go_idle      = (active && i_flush && abort_fill) || leave_active || flush_done;

  assign o_taps  = taps;
  assign o_data  = i_fir_y;
  assign o_state = state;
  assign o_busy  = (state != ST_IDLE) || inflight || o_valid;

  always_ff @(posedge i_clk_G) begin
    if (i_rst) begin
      state        <= ST_IDLE;
      taps         <= '0;
      fill_cnt     <= '0;
      flush_cnt    <= '0;
      inflight     <= 1'b0;
      emit_pending <= 1'b0;
      o_valid      <= 1'b0;
    end else begin
      inflight     <= shift;
      emit_pending <= shift && shift_emits;

      // The FIR result for a shift lands on the edge that retires inflight.
      if (inflight && emit_pending) begin
        o_valid <= 1'b1;
      end else if (o_valid && i_ready) begin
        o_valid <= 1'b0;
      end

      if (shift) begin
        taps <= {taps[N_TAPS-2:0], shift_in};
      end
      if (accept && (fill_cnt != FULL_CNT)) begin
        fill_cnt <= fill_cnt + CW'(1);
      end
      if (inject) begin
        flush_cnt <= flush_cnt + CW'(1);
      end

      case (state)
        ST_IDLE: begin
          if (i_enable) state <= ST_FILL;
        end
        ST_FILL, ST_RUN: begin
          if (i_flush) begin
            state <= abort_fill ? ST_IDLE : ST_FLUSH;
          end else if (leave_active) begin
            state <= ST_IDLE;
          end else if (fill_done) begin
            state <= ST_RUN;
          end
        end
        ST_FLUSH: begin
          if (flush_done) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase

      // Going idle always starts the next run from an empty delay line.
      if (go_idle) begin
        taps      <= '0;
        fill_cnt  <= '0;
        flush_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_fir_stream_ctrl.sv
// tb_fir_stream_ctrl: directed bench for fir_stream_ctrl, with one instance per
// warm-up mode, each driven by a registered all-0.5-coefficient FIR model.
module tb_fir_stream_ctrl;

  localparam int NB = 8;
  localparam int NT = 8;

  typedef struct {
    int en, vld, d, rdy, fl;
    int er, eva, da, evb, db, es;
  } vec_t;

  logic clk = 1'b0;
  logic rst, en, flush, valid, rdy;
  logic [NB-1:0] data;

  logic ready_a, valid_a, busy_a;
  logic [1:0] state_a;
  logic [NT*NB-1:0] taps_a;
  logic [NB-1:0] data_a, fir_a;

  logic ready_b, valid_b, busy_b;
  logic [1:0] state_b;
  logic [NT*NB-1:0] taps_b;
  logic [NB-1:0] data_b, fir_b;

  int checks = 0;
  int failures = 0;
  int hs_a = 0;
  int hs_b = 0;
  logic [NB-1:0] qa[$];
  logic [NT*NB-1:0] last_taps_a;
  vec_t vecs [19];

  logic [NB-1:0] exp_flush [7] = '{8'd17, 8'd16, 8'd15, 8'd13, 8'd10, 8'd7, 8'd4};
  logic [NB-1:0] exp_flush9 [8] = '{8'd22, 8'd21, 8'd19, 8'd17, 8'd15, 8'd12, 8'd8, 8'd4};

  always #5 clk = ~clk;

  fir_stream_ctrl #(.NB_DATA(NB), .N_TAPS(NT), .EMIT_WARMUP(1'b0)) dut_a (
    .i_clk_G(clk), .i_rst(rst), .i_enable(en), .i_flush(flush),
    .i_data(data), .i_valid(valid), .o_ready(ready_a), .o_taps(taps_a),
    .i_fir_y(fir_a), .o_data(data_a), .o_valid(valid_a), .i_ready(rdy),
    .o_state(state_a), .o_busy(busy_a)
  );

  fir_stream_ctrl #(.NB_DATA(NB), .N_TAPS(NT), .EMIT_WARMUP(1'b1)) dut_b (
    .i_clk_G(clk), .i_rst(rst), .i_enable(en), .i_flush(flush),
    .i_data(data), .i_valid(valid), .o_ready(ready_b), .o_taps(taps_b),
    .i_fir_y(fir_b), .o_data(data_b), .o_valid(valid_b), .i_ready(rdy),
    .o_state(state_b), .o_busy(busy_b)
  );

  function automatic logic [NB-1:0] firModel(input logic [NT*NB-1:0] t);
    int acc = 0;
    for (int k = 0; k < NT; k++) acc += 64 * int'($signed(t[k*NB +: NB]));
    return NB'(acc >>> 7);
  endfunction

  always @(posedge clk) begin
    fir_a <= firModel(taps_a);
    fir_b <= firModel(taps_b);
  end

  // Output handshake monitor
  always @(posedge clk) begin
    if (valid_a && rdy) begin
      qa.push_back(data_a);
      hs_a <= hs_a + 1;
      last_taps_a <= taps_a;
    end
    if (valid_b && rdy) hs_b <= hs_b + 1;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic vec_t mkVec(input int en_, input int vld_, input int d_, input int rdy_,
                                 input int fl_, input int er_, input int eva_, input int da_,
                                 input int evb_, input int db_, input int es_);
    vec_t v;
    v.en = en_; v.vld = vld_; v.d = d_; v.rdy = rdy_; v.fl = fl_;
    v.er = er_; v.eva = eva_; v.da = da_; v.evb = evb_; v.db = db_; v.es = es_;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic applyStimulus(input int e, input int v, input int d, input int r, input int f);
    @(negedge clk);
    en = (e != 0); valid = (v != 0); data = NB'(d); rdy = (r != 0); flush = (f != 0);
    #1;
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1; en = 1'b0; valid = 1'b0; data = '0; rdy = 1'b1; flush = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_state"}, 64'(state_a), 64'd0);
    checkOutput({tag, "_valid"}, 64'(valid_a), 64'd0);
    checkOutput({tag, "_ready"}, 64'(ready_a), 64'd0);
    checkOutput({tag, "_taps"},  64'(taps_a),  64'd0);
    checkOutput({tag, "_busy"},  64'(busy_a),  64'd0);
  endtask

  task automatic feedSample(input int d, input int f);
    int n = 0;
    applyStimulus(1, 0, d, 1, 0);
    while (!ready_a && n < 20) begin
      applyStimulus(1, 0, d, 1, 0);
      n++;
    end
    checkOutput("feed_ready", 64'(ready_a), 64'd1);
    valid = 1'b1;
    flush = (f != 0);
    @(negedge clk);
    valid = 1'b0;
    flush = 1'b0;
    #1;
  endtask

  task automatic waitIdle(input string tag);
    int n = 0;
    applyStimulus(0, 0, 0, 1, 0);
    while (state_a != 2'd0 && n < 80) begin
      applyStimulus(0, 0, 0, 1, 0);
      n++;
    end
    checkOutput({tag, "_to_idle"}, 64'(state_a), 64'd0);
  endtask

  initial begin
    int hs0, base;
    logic [NB-1:0] got;

    vecs[0]  = mkVec(1, 1, 1, 1, 0,  0, 0, 0,  0, 0,  0);
    vecs[1]  = mkVec(1, 1, 1, 1, 0,  1, 0, 0,  0, 0,  1);
    vecs[2]  = mkVec(1, 1, 2, 1, 0,  0, 0, 0,  0, 0,  1);
    vecs[3]  = mkVec(1, 1, 2, 1, 0,  1, 0, 0,  1, 0,  1);
    vecs[4]  = mkVec(1, 1, 3, 1, 0,  0, 0, 0,  0, 0,  1);
    vecs[5]  = mkVec(1, 1, 3, 1, 0,  1, 0, 0,  1, 1,  1);
    vecs[6]  = mkVec(1, 1, 4, 1, 0,  0, 0, 0,  0, 0,  1);
    vecs[7]  = mkVec(1, 1, 4, 1, 0,  1, 0, 0,  1, 3,  1);
    vecs[8]  = mkVec(1, 1, 5, 1, 0,  0, 0, 0,  0, 0,  1);
    vecs[9]  = mkVec(1, 1, 5, 1, 0,  1, 0, 0,  1, 5,  1);
    vecs[10] = mkVec(1, 1, 6, 1, 0,  0, 0, 0,  0, 0,  1);
    vecs[11] = mkVec(1, 1, 6, 1, 0,  1, 0, 0,  1, 7,  1);
    vecs[12] = mkVec(1, 1, 7, 1, 0,  0, 0, 0,  0, 0,  1);
    vecs[13] = mkVec(1, 1, 7, 1, 0,  1, 0, 0,  1, 10, 1);
    vecs[14] = mkVec(1, 1, 8, 1, 0,  0, 0, 0,  0, 0,  1);
    vecs[15] = mkVec(1, 1, 8, 1, 0,  1, 0, 0,  1, 14, 1);
    vecs[16] = mkVec(1, 0, 0, 1, 0,  0, 0, 0,  0, 0,  2);
    vecs[17] = mkVec(1, 0, 0, 1, 0,  1, 1, 18, 1, 18, 2);
    vecs[18] = mkVec(1, 0, 0, 1, 0,  1, 0, 0,  0, 0,  2);

    doReset();
    checkResetState("reset");

    // Warm-up of both instances from the same stimulus table
    for (int i = 0; i < 19; i++) begin
      applyStimulus(vecs[i].en, vecs[i].vld, vecs[i].d, vecs[i].rdy, vecs[i].fl);
      checkOutput($sformatf("row%0d_ready_a", i), 64'(ready_a), 64'(vecs[i].er));
      checkOutput($sformatf("row%0d_ready_b", i), 64'(ready_b), 64'(vecs[i].er));
      checkOutput($sformatf("row%0d_valid_a", i), 64'(valid_a), 64'(vecs[i].eva));
      checkOutput($sformatf("row%0d_valid_b", i), 64'(valid_b), 64'(vecs[i].evb));
      checkOutput($sformatf("row%0d_state_a", i), 64'(state_a), 64'(vecs[i].es));
      checkOutput($sformatf("row%0d_state_b", i), 64'(state_b), 64'(vecs[i].es));
      if (vecs[i].eva != 0) checkOutput($sformatf("row%0d_data_a", i), 64'(data_a), 64'(vecs[i].da));
      if (vecs[i].evb != 0) checkOutput($sformatf("row%0d_data_b", i), 64'(data_b), 64'(vecs[i].db));
    end
    checkOutput("fill_taps_a", 64'(taps_a), 64'h0102030405060708);
    checkOutput("fill_taps_b", 64'(taps_b), 64'h0102030405060708);
    checkOutput("fill_outputs_a", 64'(hs_a), 64'd1);
    checkOutput("fill_outputs_b", 64'(hs_b), 64'd8);

    // Downstream stall in RUN
    hs0 = hs_a;
    base = qa.size();
    applyStimulus(1, 1, 9, 0, 0);
    checkOutput("stall_accept9_ready", 64'(ready_a), 64'd1);
    applyStimulus(1, 1, 10, 0, 0);
    checkOutput("stall_inflight_ready", 64'(ready_a), 64'd0);
    for (int c = 0; c < 5; c++) begin
      applyStimulus(1, 1, 10, 0, 0);
      checkOutput($sformatf("stall%0d_ready", c), 64'(ready_a), 64'd0);
      checkOutput($sformatf("stall%0d_valid", c), 64'(valid_a), 64'd1);
      checkOutput($sformatf("stall%0d_data", c), 64'(data_a), 64'd22);
      checkOutput($sformatf("stall%0d_taps", c), 64'(taps_a), 64'h0203040506070809);
      checkOutput($sformatf("stall%0d_data_b", c), 64'(data_b), 64'd22);
    end
    applyStimulus(1, 1, 10, 1, 0);
    checkOutput("release_ready", 64'(ready_a), 64'd1);
    applyStimulus(1, 0, 0, 1, 0);
    checkOutput("release_taps", 64'(taps_a), 64'h030405060708090A);
    checkOutput("release_valid", 64'(valid_a), 64'd0);
    applyStimulus(1, 0, 0, 1, 0);
    checkOutput("sample10_valid", 64'(valid_a), 64'd1);
    checkOutput("sample10_data", 64'(data_a), 64'd26);
    applyStimulus(0, 0, 0, 1, 0);
    checkOutput("disable_wait_state", 64'(state_a), 64'd2);
    applyStimulus(0, 0, 0, 1, 0);
    checkOutput("disable_state", 64'(state_a), 64'd0);
    checkOutput("disable_taps", 64'(taps_a), 64'd0);
    checkOutput("disable_busy", 64'(busy_a), 64'd0);
    checkOutput("stall_outputs", 64'(hs_a - hs0), 64'd2);
    got = (qa.size() > base) ? qa[base] : 'x;
    checkOutput("stall_first_out", 64'(got), 64'd22);

    // Flush in FILL with nothing accepted returns straight to IDLE
    doReset();
    applyStimulus(1, 0, 0, 1, 0);
    applyStimulus(1, 0, 0, 1, 1);
    checkOutput("abort_fill_state", 64'(state_a), 64'd1);
    applyStimulus(0, 0, 0, 1, 0);
    checkOutput("abort_idle_state", 64'(state_a), 64'd0);

    // Flush after samples 1..8
    doReset();
    for (int s = 1; s <= 8; s++) feedSample(s, 0);
    repeat (3) applyStimulus(1, 0, 0, 1, 0);
    hs0 = hs_a;
    base = qa.size();
    applyStimulus(0, 0, 0, 1, 1);
    applyStimulus(0, 0, 0, 1, 0);
    checkOutput("flush_state", 64'(state_a), 64'd3);
    checkOutput("flush_ready", 64'(ready_a), 64'd0);
    waitIdle("flush");
    checkOutput("flush_outputs", 64'(hs_a - hs0), 64'd7);
    for (int i = 0; i < 7; i++) begin
      got = (qa.size() > base + i) ? qa[base + i] : 'x;
      checkOutput($sformatf("flush_out%0d", i), 64'(got), 64'(exp_flush[i]));
    end
    checkOutput("flush_final_taps", 64'(last_taps_a), 64'h0800000000000000);
    checkOutput("flush_idle_taps", 64'(taps_a), 64'd0);
    checkOutput("flush_idle_busy", 64'(busy_a), 64'd0);

    // Flush on the same edge as the accept of sample 9
    doReset();
    for (int s = 1; s <= 8; s++) feedSample(s, 0);
    repeat (3) applyStimulus(1, 0, 0, 1, 0);
    hs0 = hs_a;
    base = qa.size();
    feedSample(9, 1);
    checkOutput("flush9_state", 64'(state_a), 64'd3);
    waitIdle("flush9");
    checkOutput("flush9_outputs", 64'(hs_a - hs0), 64'd8);
    for (int i = 0; i < 8; i++) begin
      got = (qa.size() > base + i) ? qa[base + i] : 'x;
      checkOutput($sformatf("flush9_out%0d", i), 64'(got), 64'(exp_flush9[i]));
    end
    checkOutput("flush9_final_taps", 64'(last_taps_a), 64'h0900000000000000);

    // Reset while a result is still inside the FIR
    doReset();
    for (int s = 1; s <= 8; s++) feedSample(s, 0);
    hs0 = hs_a;
    rst = 1'b1;
    @(negedge clk);
    #1;
    checkResetState("rst_inflight");
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      applyStimulus(0, 0, 0, 1, 0);
      checkOutput($sformatf("rst_inflight_quiet%0d", c), 64'(valid_a), 64'd0);
    end
    checkOutput("rst_inflight_outputs", 64'(hs_a - hs0), 64'd0);

    // Reset while a stalled result is on the output
    doReset();
    for (int s = 1; s <= 8; s++) feedSample(s, 0);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("rst_stall_valid", 64'(valid_a), 64'd1);
    hs0 = hs_a;
    rst = 1'b1;
    @(negedge clk);
    #1;
    checkResetState("rst_valid");
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      applyStimulus(0, 0, 0, 1, 0);
      checkOutput($sformatf("rst_valid_quiet%0d", c), 64'(valid_a), 64'd0);
    end
    checkOutput("rst_valid_outputs", 64'(hs_a - hs0), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
